// File: rtl/traffic_light_intersection.sv
// traffic_light_intersection
//   Demand-actuated two-road intersection controller. Main road rests in
//   green until a side-road (or, optionally, pedestrian) request is latched.
//   The controller then sequences yellow, an all-red clearance, the side-road
//   green (optionally preceded by a pedestrian walk), side yellow and a
//   second all-red clearance, and returns to main green. Phase durations are
//   counted in tick_en strobes, so the block is clock-rate independent.
//
//   Optional feature macro: TLC_PED_EN (pedestrian walk phase, ped_pending
//   latch and walk output). Without it ped_req is ignored and walk is 0.
//
// Ports
//   clk         single clock, rising edge
//   rst_n       asynchronous active-low reset (forces ALL_RED_B, all red)
//   tick_en     timebase strobe; the phase timer only advances when high
//   side_req    side-road vehicle demand (level or one-cycle pulse)
//   ped_req     pedestrian push-button (level or one-cycle pulse)
//   main_light  main-road head {Red, Yellow, Green}
//   side_light  side-road head {Red, Yellow, Green}
//   walk        pedestrian WALK indication
//   phase       current state encoding (debug/status)

module traffic_light_intersection #(
  parameter int TIMER_W          = 8,
  parameter int MAIN_GREEN_TICKS = 10,
  parameter int SIDE_GREEN_TICKS = 6,
  parameter int YELLOW_TICKS     = 3,
  parameter int ALL_RED_TICKS    = 1,
  parameter int WALK_TICKS       = 5
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       tick_en,
  input  logic       side_req,
  input  logic       ped_req,
  output logic [2:0] main_light,
  output logic [2:0] side_light,
  output logic       walk,
  output logic [2:0] phase
);

  localparam int MAX_TICKS = 1 << TIMER_W;

  // Every duration must be representable as a last-tick timer value.
  if ((MAIN_GREEN_TICKS < 1) || (MAIN_GREEN_TICKS > MAX_TICKS) ||
      (SIDE_GREEN_TICKS < 1) || (SIDE_GREEN_TICKS > MAX_TICKS) ||
      (YELLOW_TICKS     < 1) || (YELLOW_TICKS     > MAX_TICKS) ||
      (ALL_RED_TICKS    < 1) || (ALL_RED_TICKS    > MAX_TICKS) ||
      (WALK_TICKS       < 1) || (WALK_TICKS       > MAX_TICKS)) begin : g_bad_duration
    $error("traffic_light_intersection: duration parameter outside 1..2^TIMER_W");
  end

  typedef enum logic [2:0] {
    MAIN_GREEN  = 3'd0,
    MAIN_YELLOW = 3'd1,
    ALL_RED_A   = 3'd2,
    PED_WALK    = 3'd3,
    SIDE_GREEN  = 3'd4,
    SIDE_YELLOW = 3'd5,
    ALL_RED_B   = 3'd6
  } state_t;

  localparam logic [TIMER_W-1:0] MG_LAST   = TIMER_W'(MAIN_GREEN_TICKS - 1);
  localparam logic [TIMER_W-1:0] SG_LAST   = TIMER_W'(SIDE_GREEN_TICKS - 1);
  localparam logic [TIMER_W-1:0] YEL_LAST  = TIMER_W'(YELLOW_TICKS - 1);
  localparam logic [TIMER_W-1:0] AR_LAST   = TIMER_W'(ALL_RED_TICKS - 1);
  localparam logic [TIMER_W-1:0] WALK_LAST = TIMER_W'(WALK_TICKS - 1);

  // The state register is a plain vector so the unused code 7 can exist and
  // be recovered from; the enum supplies the named encodings.
  logic [2:0]         state;
  logic [2:0]         next_state;
  logic [TIMER_W-1:0] timer;
  logic               side_pending;
  logic               ped_pending;
  logic               enter_side;

  assign phase      = state;
  assign enter_side = (next_state == SIDE_GREEN) && (state != SIDE_GREEN);

`ifdef TLC_PED_EN
  logic enter_ped;
  assign enter_ped = (next_state == PED_WALK) && (state != PED_WALK);
`else
  logic unused_ped_req;
  assign unused_ped_req = ped_req;
`endif

  function automatic logic [2:0] main_decode(input logic [2:0] s);
    case (s)
      MAIN_GREEN:  return 3'b001;
      MAIN_YELLOW: return 3'b010;
      default:     return 3'b100;
    endcase
  endfunction

  function automatic logic [2:0] side_decode(input logic [2:0] s);
    case (s)
      SIDE_GREEN:  return 3'b001;
      SIDE_YELLOW: return 3'b010;
      default:     return 3'b100;
    endcase
  endfunction

  // Next-state decision. Each timed phase leaves on the tick where the timer
  // holds its last value, so a phase of D ticks sees exactly D strobes.
  // Main green only leaves once its minimum has elapsed and a request waits.
  always_comb begin
    next_state = state;
    case (state)
      MAIN_GREEN:
        if (tick_en && (timer == MG_LAST) && (side_pending || ped_pending))
          next_state = MAIN_YELLOW;
      MAIN_YELLOW:
        if (tick_en && (timer == YEL_LAST)) next_state = ALL_RED_A;
      ALL_RED_A:
        if (tick_en && (timer == AR_LAST))
          next_state = ped_pending ? PED_WALK : SIDE_GREEN;
      PED_WALK:
        if (tick_en && (timer == WALK_LAST))
          next_state = side_pending ? SIDE_GREEN : ALL_RED_B;
      SIDE_GREEN:
        if (tick_en && (timer == SG_LAST)) next_state = SIDE_YELLOW;
      SIDE_YELLOW:
        if (tick_en && (timer == YEL_LAST)) next_state = ALL_RED_B;
      ALL_RED_B:
        if (tick_en && (timer == AR_LAST)) next_state = MAIN_GREEN;
      default:
        next_state = ALL_RED_B;
    endcase
  end

  // State, timer, request latches and registered light outputs. The lights
  // are loaded from next_state so they always match the state register and
  // come straight from flops. In the request latches a new request on the
  // clearing cycle wins, so back-to-back demand is never dropped. The main
  // green timer parks at its last value while waiting for demand.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state        <= ALL_RED_B;
      timer        <= '0;
      side_pending <= 1'b0;
      ped_pending  <= 1'b0;
      main_light   <= 3'b100;
      side_light   <= 3'b100;
      walk         <= 1'b0;
    end else begin
      state <= next_state;
      if (next_state != state)
        timer <= '0;
      else if (tick_en && !((state == MAIN_GREEN) && (timer == MG_LAST)))
        timer <= timer + TIMER_W'(1);
      side_pending <= side_req | (side_pending & ~enter_side);
`ifdef TLC_PED_EN
      ped_pending  <= ped_req | (ped_pending & ~enter_ped);
      walk         <= (next_state == PED_WALK);
`else
      ped_pending  <= 1'b0;
      walk         <= 1'b0;
`endif
      main_light   <= main_decode(next_state);
      side_light   <= side_decode(next_state);
    end
  end

endmodule
